// File: rtl/alu_req_sequencer.sv
// -----------------------------------------------------------------------------
// alu_req_sequencer
//   Two-requester front end sharing one registered ALU. Packets from two
//   valid/ready requesters are granted round-robin, one operation in flight.
//   The granted packet is issued to the ALU, the block waits a
//   command-dependent latency (LAT, or MUL_LAT for multiplies), captures the
//   ALU result/flags and returns them with the requester ID on a valid/ready
//   response port.
//
// Parameters
//   INPUT    operand width (must match the ALU)
//   LAT      ALU issue-to-result cycles, non-multiply commands (>= 1)
//   MUL_LAT  ALU issue-to-result cycles, MODE=1 CMD 1001/1010 (>= 1)
//
// Ports
//   CLK, RST                 clock (rising edge), async active-low reset
//   REQ_VALID[1:0]           per-requester packet valid
//   REQ_READY[1:0]           per-requester accept, one-hot or zero (combinational)
//   REQn_OPA/OPB/CIN/CMD/MODE/VLD   requester n packet
//   ALU_OPA/OPB/CIN/CMD/MODE/VALID  packet driven to the ALU
//   ALU_CE                   ALU clock enable
//   ALU_RES, ALU_ERR/OFLOW/COUT/G/L/E   ALU outputs
//   RSP_VALID, RSP_READY     response handshake
//   RSP_ID, RSP_RES, RSP_FLAGS   response payload, flags {ERR,OFLOW,COUT,G,L,E}
//
// Optional feature
//   ALU_REQ_SEQ_PRECHECK_EN  when defined, packets outside the legal
//                            MODE/VALID/CMD table are answered directly with
//                            ERR one cycle after accept and never reach the ALU.
// -----------------------------------------------------------------------------
module alu_req_sequencer #(
  parameter int unsigned INPUT   = 8,
  parameter int unsigned LAT     = 1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         REQ_VALID,
  output logic [1:0]         REQ_READY,
  input  logic [INPUT-1:0]   REQ0_OPA,
  input  logic [INPUT-1:0]   REQ1_OPA,
  input  logic [INPUT-1:0]   REQ0_OPB,
  input  logic [INPUT-1:0]   REQ1_OPB,
  input  logic               REQ0_CIN,
  input  logic               REQ1_CIN,
  input  logic [3:0]         REQ0_CMD,
  input  logic [3:0]         REQ1_CMD,
  input  logic               REQ0_MODE,
  input  logic               REQ1_MODE,
  input  logic [1:0]         REQ0_VLD,
  input  logic [1:0]         REQ1_VLD,
  output logic [INPUT-1:0]   ALU_OPA,
  output logic [INPUT-1:0]   ALU_OPB,
  output logic               ALU_CIN,
  output logic [3:0]         ALU_CMD,
  output logic               ALU_MODE,
  output logic [1:0]         ALU_VALID,
  output logic               ALU_CE,
  input  logic [2*INPUT-1:0] ALU_RES,
  input  logic               ALU_ERR,
  input  logic               ALU_OFLOW,
  input  logic               ALU_COUT,
  input  logic               ALU_G,
  input  logic               ALU_L,
  input  logic               ALU_E,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [2*INPUT-1:0] RSP_RES,
  output logic [5:0]         RSP_FLAGS
);

  localparam int unsigned RES_W    = 2 * INPUT;
  localparam int unsigned LMAX     = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int unsigned CNT_W    = (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [5:0]       FLAG_ERR = 6'b100000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               id_q, id_d;
  logic [INPUT-1:0]   alu_opa_q, alu_opa_d;
  logic [INPUT-1:0]   alu_opb_q, alu_opb_d;
  logic               alu_cin_q, alu_cin_d;
  logic [3:0]         alu_cmd_q, alu_cmd_d;
  logic               alu_mode_q, alu_mode_d;
  logic [1:0]         alu_valid_q, alu_valid_d;
  logic               alu_ce_q, alu_ce_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]   rsp_res_q, rsp_res_d;
  logic [5:0]         rsp_flags_q, rsp_flags_d;

  logic               grant_any;
  logic               grant_id;
  logic [1:0]         req_ready_c;
  logic               issue_ok;
  logic               is_mul;
  logic [INPUT-1:0]   sel_opa;
  logic [INPUT-1:0]   sel_opb;
  logic               sel_cin;
  logic [3:0]         sel_cmd;
  logic               sel_mode;
  logic [1:0]         sel_vld;

`ifdef ALU_REQ_SEQ_PRECHECK_EN
  // Legal MODE/VALID/CMD combinations of the ALU command set.
  function automatic logic op_legal(input logic mode, input logic [3:0] cmd,
                                    input logic [1:0] vld);
    logic ok;
    ok = 1'b0;
    if (mode) begin
      unique case (vld)
        2'b11:   ok = (cmd <= 4'd3) || ((cmd >= 4'd8) && (cmd <= 4'd12));
        2'b01:   ok = (cmd == 4'd4) || (cmd == 4'd5);
        2'b10:   ok = (cmd == 4'd6) || (cmd == 4'd7);
        default: ok = 1'b0;
      endcase
    end else begin
      unique case (vld)
        2'b11:   ok = (cmd <= 4'd5) || (cmd == 4'd12) || (cmd == 4'd13);
        2'b01:   ok = (cmd == 4'd6) || (cmd == 4'd8) || (cmd == 4'd9);
        2'b10:   ok = (cmd == 4'd7) || (cmd == 4'd10) || (cmd == 4'd11);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction
`endif

  // Round-robin pick: pointer's requester first, otherwise the other one.
  always_comb begin
    grant_any = |REQ_VALID;
    grant_id  = REQ_VALID[ptr_q] ? ptr_q : ~ptr_q;
    sel_opa   = grant_id ? REQ1_OPA  : REQ0_OPA;
    sel_opb   = grant_id ? REQ1_OPB  : REQ0_OPB;
    sel_cin   = grant_id ? REQ1_CIN  : REQ0_CIN;
    sel_cmd   = grant_id ? REQ1_CMD  : REQ0_CMD;
    sel_mode  = grant_id ? REQ1_MODE : REQ0_MODE;
    sel_vld   = grant_id ? REQ1_VLD  : REQ0_VLD;
`ifdef ALU_REQ_SEQ_PRECHECK_EN
    issue_ok  = op_legal(sel_mode, sel_cmd, sel_vld);
`else
    issue_ok  = 1'b1;
`endif
    is_mul    = alu_mode_q && ((alu_cmd_q == 4'b1001) || (alu_cmd_q == 4'b1010));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    alu_opa_d   = alu_opa_q;
    alu_opb_d   = alu_opb_q;
    alu_cin_d   = alu_cin_q;
    alu_cmd_d   = alu_cmd_q;
    alu_mode_d  = alu_mode_q;
    alu_valid_d = alu_valid_q;
    alu_ce_d    = alu_ce_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    req_ready_c = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          // READY is only raised towards a valid requester, so a grant is an accept.
          req_ready_c = grant_id ? 2'b10 : 2'b01;
          ptr_d       = ~grant_id;
          id_d        = grant_id;
          if (issue_ok) begin
            alu_opa_d   = sel_opa;
            alu_opb_d   = sel_opb;
            alu_cin_d   = sel_cin;
            alu_cmd_d   = sel_cmd;
            alu_mode_d  = sel_mode;
            alu_valid_d = sel_vld;
            alu_ce_d    = 1'b1;
            state_d     = S_ISSUE;
          end else begin
            // Rejected packet: answer with ERR, ALU untouched.
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_id;
            rsp_res_d   = '0;
            rsp_flags_d = FLAG_ERR;
            state_d     = S_RESP;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = is_mul ? MUL_LOAD : LAT_LOAD;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_res_d   = ALU_RES;
          rsp_flags_d = {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E};
          alu_ce_d    = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      alu_opa_q   <= '0;
      alu_opb_q   <= '0;
      alu_cin_q   <= 1'b0;
      alu_cmd_q   <= 4'd0;
      alu_mode_q  <= 1'b0;
      alu_valid_q <= 2'b00;
      alu_ce_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      alu_opa_q   <= alu_opa_d;
      alu_opb_q   <= alu_opb_d;
      alu_cin_q   <= alu_cin_d;
      alu_cmd_q   <= alu_cmd_d;
      alu_mode_q  <= alu_mode_d;
      alu_valid_q <= alu_valid_d;
      alu_ce_q    <= alu_ce_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  // READY is combinational; hold it low while reset is asserted.
  assign REQ_READY = req_ready_c & {2{RST}};
  assign ALU_OPA   = alu_opa_q;
  assign ALU_OPB   = alu_opb_q;
  assign ALU_CIN   = alu_cin_q;
  assign ALU_CMD   = alu_cmd_q;
  assign ALU_MODE  = alu_mode_q;
  assign ALU_VALID = alu_valid_q;
  assign ALU_CE    = alu_ce_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_RES   = rsp_res_q;
  assign RSP_FLAGS = rsp_flags_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_req_sequencer
//   Directed steps followed by random traffic. A transaction-level model
//   (round-robin pointer, busy flag, accept cycle and latency arithmetic)
//   predicts READY, ALU_CE, ALU inputs and the response; a small behavioural
//   ALU with a one/two stage output pipeline stands in for the real ALU.
// -----------------------------------------------------------------------------
module tb_alu_req_sequencer;

  localparam int unsigned W       = 8;
  localparam int unsigned LAT     = 1;
  localparam int unsigned MUL_LAT = 2;
`ifdef ALU_REQ_SEQ_PRECHECK_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] opa;
    logic [7:0] opb;
    logic       cin;
    logic [3:0] cmd;
    logic       mode;
    logic [1:0] vld;
  } pkt_t;

  logic        CLK;
  logic        RST;
  logic [1:0]  pend;
  logic [1:0]  REQ_READY;
  pkt_t        pk0, pk1;
  logic [W-1:0] ALU_OPA, ALU_OPB;
  logic        ALU_CIN, ALU_MODE, ALU_CE;
  logic [3:0]  ALU_CMD;
  logic [1:0]  ALU_VALID;
  logic [15:0] alu_res;
  logic [5:0]  alu_flags;
  logic        RSP_VALID, RSP_ID;
  logic        rr;
  logic [15:0] RSP_RES;
  logic [5:0]  RSP_FLAGS;

  alu_req_sequencer #(.INPUT(W), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(pend), .REQ_READY(REQ_READY),
    .REQ0_OPA(pk0.opa), .REQ1_OPA(pk1.opa),
    .REQ0_OPB(pk0.opb), .REQ1_OPB(pk1.opb),
    .REQ0_CIN(pk0.cin), .REQ1_CIN(pk1.cin),
    .REQ0_CMD(pk0.cmd), .REQ1_CMD(pk1.cmd),
    .REQ0_MODE(pk0.mode), .REQ1_MODE(pk1.mode),
    .REQ0_VLD(pk0.vld), .REQ1_VLD(pk1.vld),
    .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CIN(ALU_CIN),
    .ALU_CMD(ALU_CMD), .ALU_MODE(ALU_MODE), .ALU_VALID(ALU_VALID),
    .ALU_CE(ALU_CE), .ALU_RES(alu_res),
    .ALU_ERR(alu_flags[5]), .ALU_OFLOW(alu_flags[4]), .ALU_COUT(alu_flags[3]),
    .ALU_G(alu_flags[2]), .ALU_L(alu_flags[1]), .ALU_E(alu_flags[0]),
    .RSP_VALID(RSP_VALID), .RSP_READY(rr), .RSP_ID(RSP_ID),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // transaction model state
  bit   m_busy = 1'b0;
  int   m_ptr = 0;
  int   m_acc = 0;
  int   m_L = 1;
  int   m_rsp_cyc = 0;
  bit   m_ill = 1'b0;
  int   m_id = 0;
  pkt_t m_pkt;
  int   grants[$];

  // observations for directed steps
  bit          seen_rv = 1'b0;
  int          obs_lat = 0;
  int          ce_cnt = 0;
  logic        obs_id = 1'b0;
  logic [15:0] obs_res = '0;
  logic [5:0]  obs_flags = '0;

  // stimulus controls
  bit gen_rand = 1'b0;
  bit refill = 1'b0;
  bit rnd_rr = 1'b0;

  // ALU stand-in pipeline
  logic [21:0] s1 = '0, s2 = '0;
  bit          msel = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic m, input logic [3:0] c, input logic [1:0] v);
    if (m) begin
      case (v)
        2'b11:   return (c <= 3) || (c >= 8 && c <= 12);
        2'b01:   return (c == 4) || (c == 5);
        2'b10:   return (c == 6) || (c == 7);
        default: return 1'b0;
      endcase
    end else begin
      case (v)
        2'b11:   return (c <= 5) || (c == 12) || (c == 13);
        2'b01:   return (c == 6) || (c == 8) || (c == 9);
        2'b10:   return (c == 7) || (c == 10) || (c == 11);
        default: return 1'b0;
      endcase
    end
  endfunction

  function automatic bit is_mul(input pkt_t p);
    return p.mode && (p.cmd == 4'd9 || p.cmd == 4'd10);
  endfunction

  // Behavioural ALU result {res, flags}; flags = {ERR,OFLOW,COUT,G,L,E}.
  function automatic logic [21:0] alu_f(input pkt_t p);
    logic [15:0] r;
    logic [5:0]  f;
    r = '0;
    f = '0;
    if (!legal(p.mode, p.cmd, p.vld)) return {16'h0000, 6'b100000};
    if (p.mode) begin
      case (p.cmd)
        4'd0: begin r = 16'(p.opa) + 16'(p.opb); f[3] = r[8]; end
        4'd1: r = 16'(p.opa) - 16'(p.opb);
        4'd2: begin r = 16'(p.opa) + 16'(p.opb) + 16'(p.cin); f[3] = r[8]; end
        4'd8: f[2:0] = {p.opa > p.opb, p.opa < p.opb, p.opa == p.opb};
        4'd9: r = (16'(p.opa) + 16'd1) * (16'(p.opb) + 16'd1);
        4'd10: r = (16'(p.opa) << 1) * 16'(p.opb);
        default: r = {p.opb, p.opa} ^ 16'(p.cmd);
      endcase
    end else begin
      r = {8'h00, p.opa ^ p.opb} ^ 16'(p.cmd);
    end
    return {r, f};
  endfunction

  function automatic pkt_t rand_pkt();
    return pkt_t'(24'($urandom));
  endfunction

  // One clock cycle: check at negedge, advance model, then drive after posedge.
  task automatic tick();
    logic [1:0]  exp_rdy;
    bit          exp_rv, exp_ce, a_ce, a_mul;
    int          g;
    logic [21:0] exp_r, a_f;
    pkt_t        ap;
    @(negedge CLK);
    exp_rdy = 2'b00;
    g = -1;
    if (!m_busy) begin
      if (pend[m_ptr]) g = m_ptr;
      else if (pend[1 - m_ptr]) g = 1 - m_ptr;
      if (g >= 0) exp_rdy = (g == 1) ? 2'b10 : 2'b01;
    end
    exp_rv = m_busy && (cyc >= m_rsp_cyc);
    exp_ce = m_busy && !m_ill && (cyc > m_acc) && (cyc <= m_acc + m_L + 1);
    chk("req_ready", REQ_READY, exp_rdy);
    chk("rsp_valid", RSP_VALID, exp_rv);
    chk("alu_ce", ALU_CE, exp_ce);
    if (exp_ce)
      chk("alu_inputs", {ALU_OPA, ALU_OPB, ALU_CIN, ALU_CMD, ALU_MODE, ALU_VALID}, m_pkt);
    if (exp_rv) begin
      exp_r = m_ill ? {16'h0000, 6'b100000} : alu_f(m_pkt);
      chk("rsp_id", RSP_ID, m_id);
      chk("rsp_res", RSP_RES, exp_r[21:6]);
      chk("rsp_flags", RSP_FLAGS, exp_r[5:0]);
    end
    if (ALU_CE) ce_cnt++;
    if (RSP_VALID && !seen_rv) begin
      seen_rv = 1'b1;
      obs_lat = cyc - m_acc;
      obs_id = RSP_ID;
      obs_res = RSP_RES;
      obs_flags = RSP_FLAGS;
    end
    if (g >= 0) begin
      m_busy = 1'b1;
      m_acc = cyc;
      m_id = g;
      m_pkt = (g == 1) ? pk1 : pk0;
      m_ptr = 1 - g;
      m_L = is_mul(m_pkt) ? MUL_LAT : LAT;
      m_ill = PRE && !legal(m_pkt.mode, m_pkt.cmd, m_pkt.vld);
      m_rsp_cyc = m_ill ? cyc + 1 : cyc + m_L + 2;
      grants.push_back(g);
      ce_cnt = 0;
      seen_rv = 1'b0;
    end else if (exp_rv && rr) begin
      m_busy = 1'b0;
    end
    a_ce = ALU_CE;
    ap = {ALU_OPA, ALU_OPB, ALU_CIN, ALU_CMD, ALU_MODE, ALU_VALID};
    a_f = alu_f(ap);
    a_mul = is_mul(ap);
    @(posedge CLK);
    #1;
    cyc++;
    if (a_ce) begin
      s2 = s1;
      s1 = a_f;
      msel = a_mul;
    end
    {alu_res, alu_flags} = msel ? s2 : s1;
    if (g >= 0) pend[g] = 1'b0;
    if (gen_rand || refill) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && (refill || $urandom_range(0, 2) == 0)) begin
          if (i == 0) pk0 = rand_pkt(); else pk1 = rand_pkt();
          pend[i] = 1'b1;
        end
      end
    end
    if (rnd_rr) rr = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int n;
    RST = 1'b0;
    pend = 2'b00;
    rr = 1'b1;
    pk0 = '0;
    pk1 = '0;
    alu_res = '0;
    alu_flags = '0;
    #2;
    chk("reset_outputs", {REQ_READY, ALU_OPA, ALU_OPB, ALU_CIN, ALU_CMD, ALU_MODE, ALU_VALID,
                          ALU_CE, RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS}, '0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // single add on requester 0
    pk0 = {8'hFF, 8'h01, 1'b0, 4'b0000, 1'b1, 2'b11};
    pend = 2'b01;
    repeat (8) tick();
    chk("t1_seen", seen_rv, 1'b1);
    chk("t1_latency", obs_lat, 3);
    chk("t1_id", obs_id, 1'b0);
    chk("t1_res", obs_res, 16'h0100);
    chk("t1_flags", obs_flags, 6'b001000);

    // multiply on requester 1
    pk1 = {8'd3, 8'd4, 1'b0, 4'b1001, 1'b1, 2'b11};
    pend = 2'b10;
    repeat (8) tick();
    chk("t2_seen", seen_rv, 1'b1);
    chk("t2_latency", obs_lat, 4);
    chk("t2_id", obs_id, 1'b1);
    chk("t2_res", obs_res, 16'd20);
    chk("t2_ce_cycles", ce_cnt, 3);

    // both requesters continuously valid
    grants.delete();
    pk0 = rand_pkt();
    pk1 = rand_pkt();
    pend = 2'b11;
    refill = 1'b1;
    for (int k = 0; k < 80 && grants.size() < 4; k++) tick();
    refill = 1'b0;
    chk("t3_grant_count", grants.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk("t3_grant_order", grants[i], i % 2);
    repeat (20) tick();

    // response backpressure with the other requester waiting
    rr = 1'b0;
    pk0 = rand_pkt();
    pk1 = rand_pkt();
    pend = 2'b11;
    for (int k = 0; k < 20 && !(m_busy && seen_rv); k++) tick();
    chk("bp_response_seen", m_busy && seen_rv, 1'b1);
    repeat (5) tick();
    chk("bp_req_ready_low", REQ_READY, 2'b00);
    chk("bp_rsp_held", RSP_VALID, 1'b1);
    n = grants.size();
    rr = 1'b1;
    tick();
    tick();
    chk("bp_regrant_next_cycle", grants.size(), n + 1);
    repeat (20) tick();

    // illegal packet: MODE=0 CMD=1111 VALID=11
    pk1 = {8'h12, 8'h34, 1'b0, 4'b1111, 1'b0, 2'b11};
    pend = 2'b10;
    repeat (8) tick();
    chk("pc_seen", seen_rv, 1'b1);
    chk("pc_flags", obs_flags, 6'b100000);
    chk("pc_res", obs_res, 16'h0000);
`ifdef ALU_REQ_SEQ_PRECHECK_EN
    chk("pc_latency", obs_lat, 1);
    chk("pc_ce_cycles", ce_cnt, 0);
`else
    chk("pc_latency", obs_lat, 3);
    chk("pc_ce_cycles", ce_cnt, 2);
`endif

    // reset during WAIT of a multiply from requester 0
    pk0 = {8'd5, 8'd6, 1'b0, 4'b1001, 1'b1, 2'b11};
    pend = 2'b01;
    for (int k = 0; k < 20 && !(m_busy && cyc == m_acc + 2); k++) tick();
    chk("rst_reached_wait", m_busy && cyc == m_acc + 2, 1'b1);
    RST = 1'b0;
    #1;
    chk("rst_midop_outputs", {REQ_READY, ALU_OPA, ALU_OPB, ALU_CIN, ALU_CMD, ALU_MODE, ALU_VALID,
                              ALU_CE, RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS}, '0);
    pk0 = {8'h0F, 8'h01, 1'b0, 4'b0000, 1'b1, 2'b11};
    pk1 = {8'h0E, 8'h02, 1'b0, 4'b0001, 1'b1, 2'b11};
    pend = 2'b11;
    #1;
    chk("rst_ready_held_low", REQ_READY, 2'b00);
    m_busy = 1'b0;
    m_ptr = 0;
    seen_rv = 1'b0;
    grants.delete();
    @(posedge CLK);
    #1;
    cyc++;
    RST = 1'b1;
    for (int k = 0; k < 5 && grants.size() == 0; k++) tick();
    chk("rst_grant_seen", grants.size() > 0, 1'b1);
    if (grants.size() > 0) chk("rst_first_grant", grants[0], 0);
    repeat (12) tick();

    // random traffic with random response backpressure
    gen_rand = 1'b1;
    rnd_rr = 1'b1;
    repeat (500) tick();
    gen_rand = 1'b0;
    rnd_rr = 1'b0;
    rr = 1'b1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_req_sequencer.md
Name: alu_req_sequencer

Overview:
- Two-requester front end for the registered ALU; the block sequences and shares a single ALU instance between the two requesters.
- Accepts operation packets from two valid/ready requesters and arbitrates round-robin, with one operation in flight at a time.
- Drives the ALU operand/control inputs and waits a command-dependent latency.
- Captures the ALU result and flags, then returns them with the requester ID on a valid/ready response port.

Parameters:
- INPUT, 8, operand width; must match the ALU.
- LAT, 1, cycles from ALU issue to valid ALU outputs for non-multiply commands (≥1).
- MUL_LAT, 2, same for the multiply commands, MODE=1 with CMD 4'b1001 or 4'b1010 (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ_VALID  in  2  per-requester packet valid; bit i = requester i.
- REQ_READY  out  2  per-requester accept; one-hot or zero.
- REQ0_OPA, REQ1_OPA  in  INPUT  operand A.
- REQ0_OPB, REQ1_OPB  in  INPUT  operand B.
- REQ0_CIN, REQ1_CIN  in  1  carry in.
- REQ0_CMD, REQ1_CMD  in  4  ALU command.
- REQ0_MODE, REQ1_MODE  in  1  1 = arithmetic, 0 = logical.
- REQ0_VLD, REQ1_VLD  in  2  operand-valid code (ALU VALID).
- ALU_OPA, ALU_OPB  out  INPUT  operands to the ALU.
- ALU_CIN  out  1  carry to the ALU.
- ALU_CMD  out  4  command to the ALU.
- ALU_MODE  out  1  mode to the ALU.
- ALU_VALID  out  2  operand-valid code to the ALU.
- ALU_CE  out  1  ALU clock enable.
- ALU_RES  in  2*INPUT  ALU result.
- ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E  in  1 each  ALU flags.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response accept.
- RSP_ID  out  1  requester ID of the response.
- RSP_RES  out  2*INPUT  captured result.
- RSP_FLAGS  out  6  {ERR,OFLOW,COUT,G,L,E}.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-low.
- Reset (RST=0) forces: state IDLE, all outputs 0, round-robin pointer = requester 0, counter 0.
- Reset asserted mid-operation aborts the operation. No response is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant:
  - REQ_READY[g]=1 combinationally for granted g.
  - g is the pointer's requester if it is valid, else the other requester if valid.
  - Handshake (VALID&READY) at the clock edge latches the packet and ID g; next state ISSUE.
  - Pointer becomes 1-g on every grant.
  - Both valid in the same cycle: only the pointer's requester is granted; the loser waits and is served next.
- REQ_READY = 0 in all states except IDLE.
- ISSUE (1 cycle):
  - ALU_* = latched packet, ALU_CE=1.
  - Counter loads L-1, where L=MUL_LAT for multiply commands and L=LAT otherwise.
  - Next state WAIT.
- WAIT:
  - ALU_CE=1 and ALU inputs held stable.
  - When counter=0: RSP_RES/RSP_FLAGS capture the ALU outputs at that edge, RSP_ID = latched ID, next state RESP.
  - Otherwise the counter decrements.
- RESP:
  - RSP_VALID=1; RSP_* held stable until RSP_READY=1.
  - Handshake edge: RSP_VALID→0 and next state IDLE. A new grant is possible in the following cycle.
- ALU_CE=0 in IDLE and RESP. ALU_* data outputs keep their last values.
- Latency: accept edge → RSP_VALID high after 1+L+1 cycles. Throughput is 1 op per L+3 cycles at best (RSP_READY tied 1).
- RSP_FLAGS and RSP_RES are passed unchanged from the ALU; the sequencer does no arithmetic.

Optional Feature:
- Macro: ALU_REQ_SEQ_PRECHECK_EN.
- Defined: on accept, the latched packet is checked against the legal table:
  - MODE=1: VALID 11 with CMD 0–3, 8–12; VALID 01 with CMD 4–5; VALID 10 with CMD 6–7.
  - MODE=0: VALID 11 with CMD 0–5, 12–13; VALID 01 with CMD 6, 8, 9; VALID 10 with CMD 7, 10, 11.
  - Any other combination is illegal: IDLE→RESP directly, ALU_CE stays 0, RSP_RES=0, RSP_FLAGS=6'b100000. Response appears 1 cycle after accept.
  - Rotate with nonzero OPB high bits is legal; the ALU reports it.
- Undefined: every packet is issued. Illegal combinations return the ALU's own ERR after the normal latency.

Test Plan:
- Single op: req0 MODE=1 CMD=0000 VLD=11 OPA=8'hFF OPB=8'h01, LAT=1 → RSP_VALID 3 cycles after accept, RSP_ID=0, RSP_RES=16'h0100, RSP_FLAGS=6'b001000.
- Multiply latency: req1 MODE=1 CMD=1001 OPA=3 OPB=4, MUL_LAT=2 → ALU_CE high 3 cycles, RSP_RES=20, RSP_ID=1, response 4 cycles after accept.
- Arbitration: both requesters valid continuously for 4 ops → grants 0,1,0,1. Each requester keeps REQ_VALID with stable data until its READY.
- Backpressure: RSP_READY=0 for 5 cycles → RSP_* stable, REQ_READY=0 throughout. Grant resumes the cycle after the RSP handshake.
- Reset mid-op: RST=0 during WAIT → all outputs 0 immediately. After release with both valid, requester 0 is granted first.
- Precheck: MODE=0 CMD=1111 VLD=11 → with macro, RSP_FLAGS=6'b100000 one cycle after accept and ALU_CE never high. Without macro, normal latency and ERR taken from the ALU.
